// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback stage.
package wb_pkg;

  typedef enum logic [1:0] {IDLE, HOLD, LWAIT, LWB} wb_state_t;

  localparam int CNT_W   = 3;  // holds LOAD_LAT-1 for LOAD_LAT up to 7
  localparam int R0_ADDR = 0;

endpackage

// File: rtl/wb_stage_if.sv
// Execute-to-writeback result handshake; the stage accepts when ex_valid && ex_ready.
interface wb_stage_if #(
  parameter int W = 8,
  parameter int D = 3
);
  logic         ex_valid;
  logic         ex_ready;
  logic [D-1:0] ex_waddr;
  logic [W-1:0] ex_wdata;
  logic         ex_is_load;
  logic         ex_is_mov;

  modport master (
    output ex_valid, ex_waddr, ex_wdata, ex_is_load, ex_is_mov,
    input  ex_ready
  );

  modport slave (
    input  ex_valid, ex_waddr, ex_wdata, ex_is_load, ex_is_mov,
    output ex_ready
  );
endinterface

// File: rtl/wb_fwd_cmp.sv
// Combinational read-address compare: forward enables in HOLD/LWB and load-use hazard in LWAIT.
// Zero latency, no flow control.
module wb_fwd_cmp
  import wb_pkg::*;
#(
  parameter int D = 3
) (
  input  wb_state_t    state_i,
  input  logic [D-1:0] waddr_i,
  input  logic [D-1:0] pend_dest_i,
  input  logic [D-1:0] rd_addr_a_i,
  input  logic [D-1:0] rd_addr_b_i,
  output logic         fwd_a_en_o,
  output logic         fwd_b_en_o,
  output logic         hazard_o
);

  always_comb begin
    fwd_a_en_o = 1'b0;
    fwd_b_en_o = 1'b0;
    hazard_o   = 1'b0;
    case (state_i)
      HOLD, LWB: begin
        fwd_a_en_o = (rd_addr_a_i == waddr_i);
        fwd_b_en_o = (rd_addr_b_i == waddr_i);
      end
      LWAIT: begin
        hazard_o = (rd_addr_a_i == pend_dest_i) || (rd_addr_b_i == pend_dest_i);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: ALU/MOV results write one cycle after accept, loads LOAD_LAT+1 cycles after.
// ex_ready drops for the LOAD_LAT cycles a load is in flight and while Reset is high.
module wb_stage
  import wb_pkg::*;
#(
  parameter int W        = 8,
  parameter int D        = 3,
  parameter int LOAD_LAT = 1
) (
  input  logic         Clk,
  input  logic         Reset,
  wb_stage_if.slave    ex,
  input  logic [W-1:0] mem_rdata,
  input  logic [D-1:0] rd_addr_a,
  input  logic [D-1:0] rd_addr_b,
  output logic         fwd_a_en,
  output logic         fwd_b_en,
  output logic [W-1:0] fwd_data,
  output logic         hazard,
  output logic         WriteEn,
  output logic [D-1:0] Waddr,
  output logic [W-1:0] DataIn
);

  wb_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [D-1:0]     waddr_q, waddr_d;
  logic [W-1:0]     wdata_q, wdata_d;
  logic [D-1:0]     pend_dest_q, pend_dest_d;

  logic         accept;
  logic         load_done;
  logic [D-1:0] dest;

  assign ex.ex_ready = !Reset && (state_q != LWAIT);
  assign accept      = ex.ex_valid && ex.ex_ready;
  assign dest        = ex.ex_is_mov ? D'(R0_ADDR) : ex.ex_waddr;
  assign load_done   = (cnt_q == CNT_W'(LOAD_LAT - 1));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    pend_dest_d = pend_dest_q;
    case (state_q)
      LWAIT: begin
        if (load_done) begin
          state_d = LWB;
          waddr_d = pend_dest_q;
          wdata_d = mem_rdata;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        // IDLE, HOLD and LWB all take a new result the same way.
        if (accept) begin
          if (ex.ex_is_load) begin
            state_d     = LWAIT;
            cnt_d       = '0;
            pend_dest_d = dest;
          end else begin
            state_d = HOLD;
            waddr_d = dest;
            wdata_d = ex.ex_wdata;
          end
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      pend_dest_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      pend_dest_q <= pend_dest_d;
    end
  end

  assign WriteEn  = (state_q == HOLD) || (state_q == LWB);
  assign Waddr    = waddr_q;
  assign DataIn   = wdata_q;
  assign fwd_data = wdata_q;

  wb_fwd_cmp #(.D(D)) u_fwd_cmp (
    .state_i     (state_q),
    .waddr_i     (waddr_q),
    .pend_dest_i (pend_dest_q),
    .rd_addr_a_i (rd_addr_a),
    .rd_addr_b_i (rd_addr_b),
    .fwd_a_en_o  (fwd_a_en),
    .fwd_b_en_o  (fwd_b_en),
    .hazard_o    (hazard)
  );

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: one instance with LOAD_LAT=1, one with LOAD_LAT=3, writes checked against a scoreboard.
module tb_wb_stage;

  localparam int W = 8;
  localparam int D = 3;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;
  logic Reset;

  wb_stage_if #(.W(W), .D(D)) ex1 ();
  wb_stage_if #(.W(W), .D(D)) ex3 ();

  logic [W-1:0] mem1, mem3, fd1, fd3, di1, di3;
  logic [D-1:0] ra1, rb1, ra3, rb3, wa1, wa3;
  logic         fa1, fb1, hz1, we1, fa3, fb3, hz3, we3;

  wb_stage #(.W(W), .D(D), .LOAD_LAT(1)) dut1 (
    .Clk(Clk), .Reset(Reset), .ex(ex1), .mem_rdata(mem1),
    .rd_addr_a(ra1), .rd_addr_b(rb1), .fwd_a_en(fa1), .fwd_b_en(fb1),
    .fwd_data(fd1), .hazard(hz1), .WriteEn(we1), .Waddr(wa1), .DataIn(di1)
  );

  wb_stage #(.W(W), .D(D), .LOAD_LAT(3)) dut3 (
    .Clk(Clk), .Reset(Reset), .ex(ex3), .mem_rdata(mem3),
    .rd_addr_a(ra3), .rd_addr_b(rb3), .fwd_a_en(fa3), .fwd_b_en(fb3),
    .fwd_data(fd3), .hazard(hz3), .WriteEn(we3), .Waddr(wa3), .DataIn(di3)
  );

  typedef struct {
    logic [D-1:0] addr;
    logic [W-1:0] data;
    int           due;
  } exp_t;

  typedef struct {
    logic         is_load;
    logic         is_mov;
    logic [D-1:0] waddr;
    logic [W-1:0] wdata;
    logic [W-1:0] mdata;
    logic [D-1:0] ra;
    logic [D-1:0] rb;
    logic [D-1:0] e_addr;
    logic [W-1:0] e_data;
    logic         e_fa;
    logic         e_fb;
    logic         e_hz;
  } vec_t;

  exp_t q1[$];
  exp_t q3[$];
  vec_t vt[7];
  int   cyc;
  int   n_cmp;
  int   n_bad;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push1(input logic [D-1:0] a, input logic [W-1:0] d, input int due);
    exp_t e;
    e.addr = a; e.data = d; e.due = due;
    q1.push_back(e);
  endtask

  task automatic push3(input logic [D-1:0] a, input logic [W-1:0] d, input int due);
    exp_t e;
    e.addr = a; e.data = d; e.due = due;
    q3.push_back(e);
  endtask

  // Advance to the next falling edge and score any register-file write seen there.
  task automatic tick();
    exp_t e;
    @(negedge Clk);
    cyc++;
    if (q1.size() > 0 && q1[0].due < cyc) begin
      chk("dut1_write_late", cyc, q1[0].due);
      void'(q1.pop_front());
    end
    if (we1 === 1'b1) begin
      if (q1.size() == 0) chk("dut1_spurious_write", we1, 0);
      else begin
        e = q1.pop_front();
        chk("dut1_waddr", wa1, e.addr);
        chk("dut1_wdata", di1, e.data);
        chk("dut1_wcycle", cyc, e.due);
      end
    end
    if (q3.size() > 0 && q3[0].due < cyc) begin
      chk("dut3_write_late", cyc, q3[0].due);
      void'(q3.pop_front());
    end
    if (we3 === 1'b1) begin
      if (q3.size() == 0) chk("dut3_spurious_write", we3, 0);
      else begin
        e = q3.pop_front();
        chk("dut3_waddr", wa3, e.addr);
        chk("dut3_wdata", di3, e.data);
        chk("dut3_wcycle", cyc, e.due);
      end
    end
  endtask

  initial begin
    vec_t v;
    cyc = 0; n_cmp = 0; n_bad = 0;
    Reset = 1'b1;
    ex1.ex_valid = 1'b0; ex1.ex_waddr = '0; ex1.ex_wdata = '0; ex1.ex_is_load = 1'b0; ex1.ex_is_mov = 1'b0;
    ex3.ex_valid = 1'b0; ex3.ex_waddr = '0; ex3.ex_wdata = '0; ex3.ex_is_load = 1'b0; ex3.ex_is_mov = 1'b0;
    mem1 = '0; mem3 = '0; ra1 = '0; rb1 = '0; ra3 = '0; rb3 = '0;

    //          load  mov   waddr wdata  mdata  ra    rb    e_addr e_data fa    fb    hz
    vt[0] = '{1'b0, 1'b0, 3'd3, 8'h5A, 8'h00, 3'd3, 3'd4, 3'd3, 8'h5A, 1'b1, 1'b0, 1'b0};
    vt[1] = '{1'b0, 1'b1, 3'd5, 8'h40, 8'h00, 3'd0, 3'd5, 3'd0, 8'h40, 1'b1, 1'b0, 1'b0};
    vt[2] = '{1'b1, 1'b0, 3'd6, 8'h00, 8'h3E, 3'd1, 3'd6, 3'd6, 8'h3E, 1'b0, 1'b1, 1'b1};
    vt[3] = '{1'b1, 1'b1, 3'd4, 8'h99, 8'h77, 3'd4, 3'd0, 3'd0, 8'h77, 1'b0, 1'b1, 1'b1};
    vt[4] = '{1'b0, 1'b0, 3'd7, 8'hFF, 8'h00, 3'd7, 3'd7, 3'd7, 8'hFF, 1'b1, 1'b1, 1'b0};
    vt[5] = '{1'b1, 1'b0, 3'd2, 8'h12, 8'h81, 3'd3, 3'd5, 3'd2, 8'h81, 1'b0, 1'b0, 1'b0};
    vt[6] = '{1'b0, 1'b0, 3'd0, 8'h01, 8'h00, 3'd0, 3'd0, 3'd0, 8'h01, 1'b1, 1'b1, 1'b0};

    // Reset state
    tick();
    tick();
    chk("rst_ready1", ex1.ex_ready, 0);
    chk("rst_ready3", ex3.ex_ready, 0);
    chk("rst_we1", we1, 0);
    chk("rst_waddr1", wa1, 0);
    chk("rst_datain1", di1, 0);
    chk("rst_fwd_data1", fd1, 0);
    chk("rst_fwd_a1", fa1, 0);
    chk("rst_fwd_b1", fb1, 0);
    chk("rst_hazard1", hz1, 0);
    chk("rst_we3", we3, 0);
    Reset = 1'b0;
    tick();
    chk("idle_ready1", ex1.ex_ready, 1);
    chk("idle_fwd_a1", fa1, 0);

    // Single transactions on the LOAD_LAT=1 instance
    for (int i = 0; i < 7; i++) begin
      v = vt[i];
      ex1.ex_valid = 1'b1; ex1.ex_is_load = v.is_load; ex1.ex_is_mov = v.is_mov;
      ex1.ex_waddr = v.waddr; ex1.ex_wdata = v.wdata;
      ra1 = v.ra; rb1 = v.rb; mem1 = ~v.mdata;
      chk("vec_ready_in", ex1.ex_ready, 1);
      push1(v.e_addr, v.e_data, cyc + 1 + (v.is_load ? 1 : 0));
      tick();
      ex1.ex_valid = 1'b0; ex1.ex_wdata = 8'hA5;
      if (v.is_load) begin
        chk("vec_lwait_ready", ex1.ex_ready, 0);
        chk("vec_lwait_hazard", hz1, v.e_hz);
        chk("vec_lwait_fwd_a", fa1, 0);
        chk("vec_lwait_fwd_b", fb1, 0);
        mem1 = v.mdata;
        tick();
        mem1 = ~v.mdata;
      end
      chk("vec_fwd_a", fa1, v.e_fa);
      chk("vec_fwd_b", fb1, v.e_fb);
      chk("vec_fwd_data", fd1, v.e_data);
      chk("vec_ready_out", ex1.ex_ready, 1);
      tick();
    end

    // Back-to-back: ALU, ALU, then a load straight out of HOLD
    ex1.ex_valid = 1'b1; ex1.ex_is_load = 1'b0; ex1.ex_is_mov = 1'b0;
    ex1.ex_waddr = 3'd1; ex1.ex_wdata = 8'h11; mem1 = 8'hEE;
    push1(3'd1, 8'h11, cyc + 1);
    tick();
    chk("b2b_ready1", ex1.ex_ready, 1);
    ex1.ex_waddr = 3'd2; ex1.ex_wdata = 8'h22;
    push1(3'd2, 8'h22, cyc + 1);
    tick();
    chk("b2b_ready2", ex1.ex_ready, 1);
    ex1.ex_is_load = 1'b1; ex1.ex_waddr = 3'd5; ex1.ex_wdata = 8'h00;
    push1(3'd5, 8'h55, cyc + 2);
    tick();
    chk("b2b_lwait_ready", ex1.ex_ready, 0);
    ex1.ex_valid = 1'b0; ex1.ex_is_load = 1'b0;
    mem1 = 8'h55;
    tick();
    mem1 = 8'h00;
    chk("b2b_lwb_ready", ex1.ex_ready, 1);
    tick();

    // LOAD_LAT=3: ready low exactly three cycles, write four cycles after accept
    ex3.ex_valid = 1'b1; ex3.ex_is_load = 1'b1; ex3.ex_waddr = 3'd7; ex3.ex_wdata = 8'h00;
    ra3 = 3'd7; rb3 = 3'd2; mem3 = 8'h01;
    push3(3'd7, 8'hC3, cyc + 4);
    tick();
    ex3.ex_valid = 1'b0; ex3.ex_is_load = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      chk("lat3_ready_low", ex3.ex_ready, 0);
      chk("lat3_hazard", hz3, 1);
      mem3 = (k == 3) ? 8'hC3 : (8'h3C ^ 8'(k));
      tick();
    end
    mem3 = 8'h00;
    chk("lat3_ready_back", ex3.ex_ready, 1);
    chk("lat3_fwd_a", fa3, 1);
    chk("lat3_fwd_data", fd3, 8'hC3);
    tick();

    // Reset while a load is in flight: that load must never be written
    ex3.ex_valid = 1'b1; ex3.ex_is_load = 1'b1; ex3.ex_waddr = 3'd4;
    ra3 = 3'd4; rb3 = 3'd1; mem3 = 8'h99;
    tick();
    ex3.ex_valid = 1'b0; ex3.ex_is_load = 1'b0;
    chk("rstl_hazard_before", hz3, 1);
    tick();
    Reset = 1'b1;
    tick();
    chk("rstl_ready", ex3.ex_ready, 0);
    chk("rstl_we", we3, 0);
    chk("rstl_waddr", wa3, 0);
    chk("rstl_datain", di3, 0);
    chk("rstl_fwd_data", fd3, 0);
    chk("rstl_fwd_a", fa3, 0);
    chk("rstl_fwd_b", fb3, 0);
    chk("rstl_hazard", hz3, 0);
    Reset = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    chk("rstl_ready_after", ex3.ex_ready, 1);
    chk("rstl_we_after", we3, 0);

    chk("q1_drained", q1.size(), 0);
    chk("q3_drained", q3.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
